// File: rtl/rip_common.sv
// rtl/rip_common.sv - shared widths, enums and helpers for the rip memory subsystem
package rip_common;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 10;
  localparam int NUM_COL    = DATA_WIDTH / 8;

  // Who owns the read data coming back from the memory next cycle
  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IF,
    OWN_MA,
    OWN_LD
  } arb_owner_t;

  // RUN: core pipeline uses memory; LOAD: loader owns memory, core held
  typedef enum logic {
    ARB_RUN,
    ARB_LOAD
  } arb_state_t;

  // Byte address to word address of the memory array
  function automatic logic [ADDR_WIDTH-1:0] word_addr(input logic [DATA_WIDTH-1:0] byte_addr);
    return byte_addr[ADDR_WIDTH+1:2];
  endfunction

endpackage

// File: rtl/rip_mem_arbiter.sv
// rtl/rip_mem_arbiter.sv - single-port RAM arbiter for loader, data and fetch requesters
module rip_mem_arbiter
  import rip_common::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  ld_req,
  input  logic [DATA_WIDTH-1:0] ld_addr,
  input  logic [NUM_COL-1:0]    ld_we,
  input  logic [DATA_WIDTH-1:0] ld_wdata,
  output logic                  ld_gnt,

  input  logic                  ma_req,
  input  logic [DATA_WIDTH-1:0] ma_addr,
  input  logic [NUM_COL-1:0]    ma_we,
  input  logic [DATA_WIDTH-1:0] ma_wdata,
  output logic                  ma_gnt,
  output logic                  ma_rvalid,
  output logic [DATA_WIDTH-1:0] ma_rdata,

  input  logic                  if_req,
  input  logic [DATA_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_WIDTH-1:0] if_rdata,

  output logic                  mem_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [NUM_COL-1:0]    mem_we,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,

  output logic                  cpu_hold
);

  // A limit of 0 still needs a 1-bit counter that sits permanently at its maximum
  localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  arb_state_t       state;
  arb_owner_t       owner_q;
  logic [CNT_W-1:0] starve_cnt;
  logic             run_mode;
  logic             if_urgent;

  assign run_mode  = (state == ARB_RUN);
  assign if_urgent = (starve_cnt == CNT_MAX);

  // Only the word-address bits reach the array; the rest are alignment/out-of-range bits
  logic unused_addr_bits;
  assign unused_addr_bits = ^{ld_addr[1:0], ld_addr[DATA_WIDTH-1:ADDR_WIDTH+2],
                              ma_addr[1:0], ma_addr[DATA_WIDTH-1:ADDR_WIDTH+2],
                              if_addr[1:0], if_addr[DATA_WIDTH-1:ADDR_WIDTH+2]};

  // Fixed priority: loader first, then a starved fetch, then data over fetch; nothing during reset
  always_comb begin
    ld_gnt = 1'b0;
    ma_gnt = 1'b0;
    if_gnt = 1'b0;
    if (!rst) begin
      if (ld_req) begin
        ld_gnt = 1'b1;
      end else if (run_mode) begin
        if (if_req && (if_urgent || !ma_req)) begin
          if_gnt = 1'b1;
        end else if (ma_req) begin
          ma_gnt = 1'b1;
        end
      end
    end
  end

  // Steer the winning request onto the memory port; idle port is driven to zero
  always_comb begin
    mem_en    = 1'b0;
    mem_addr  = '0;
    mem_we    = '0;
    mem_wdata = '0;
    if (ld_gnt) begin
      mem_en    = 1'b1;
      mem_addr  = word_addr(ld_addr);
      mem_we    = ld_we;
      mem_wdata = ld_wdata;
    end else if (ma_gnt) begin
      mem_en    = 1'b1;
      mem_addr  = word_addr(ma_addr);
      mem_we    = ma_we;
      mem_wdata = ma_wdata;
    end else if (if_gnt) begin
      mem_en    = 1'b1;
      mem_addr  = word_addr(if_addr);
    end
  end

  // Mode machine: enter LOAD on a loader grant, leave on the first idle loader cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ARB_RUN;
      cpu_hold <= 1'b0;
    end else begin
      case (state)
        ARB_RUN: begin
          if (ld_gnt) begin
            state    <= ARB_LOAD;
            cpu_hold <= 1'b1;
          end
        end
        ARB_LOAD: begin
          if (!ld_req) begin
            state    <= ARB_RUN;
            cpu_hold <= 1'b0;
          end
        end
        default: begin
          state    <= ARB_RUN;
          cpu_hold <= 1'b0;
        end
      endcase
    end
  end

  // Count consecutive refused fetch cycles; frozen while the loader owns memory
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (run_mode) begin
      if (!if_req || if_gnt) begin
        starve_cnt <= '0;
      end else if (!if_urgent) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end
    end
  end

  // Tag next cycle's read data with its owner; loader reads and all writes return nothing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q <= OWN_NONE;
    end else if (if_gnt) begin
      owner_q <= OWN_IF;
    end else if (ma_gnt && (ma_we == '0)) begin
      owner_q <= OWN_MA;
    end else begin
      owner_q <= OWN_NONE;
    end
  end

  assign if_rvalid = (owner_q == OWN_IF);
  assign ma_rvalid = (owner_q == OWN_MA);
  assign if_rdata  = mem_rdata;
  assign ma_rdata  = mem_rdata;

endmodule

// File: tb/tb_rip_mem_arbiter.sv
// tb/tb_rip_mem_arbiter.sv - self-checking bench for rip_mem_arbiter
module tb_rip_mem_arbiter;
  import rip_common::*;

  localparam int LIMIT = 4;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                  ld_req, ma_req, if_req;
  logic [DATA_WIDTH-1:0] ld_addr, ld_wdata, ma_addr, ma_wdata, if_addr;
  logic [NUM_COL-1:0]    ld_we, ma_we;

  logic                  ld_gnt, ma_gnt, if_gnt, ma_rvalid, if_rvalid, mem_en, cpu_hold;
  logic [DATA_WIDTH-1:0] ma_rdata, if_rdata, mem_wdata;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [NUM_COL-1:0]    mem_we;
  logic [DATA_WIDTH-1:0] mem_rdata = '0;

  logic                  z_ld_gnt, z_ma_gnt, z_if_gnt, z_ma_rvalid, z_if_rvalid, z_mem_en, z_cpu_hold;
  logic [DATA_WIDTH-1:0] z_ma_rdata, z_if_rdata, z_mem_wdata;
  logic [ADDR_WIDTH-1:0] z_mem_addr;
  logic [NUM_COL-1:0]    z_mem_we;
  logic [DATA_WIDTH-1:0] z_mem_rdata = '0;

  rip_mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_we(ld_we), .ld_wdata(ld_wdata), .ld_gnt(ld_gnt),
    .ma_req(ma_req), .ma_addr(ma_addr), .ma_we(ma_we), .ma_wdata(ma_wdata), .ma_gnt(ma_gnt),
    .ma_rvalid(ma_rvalid), .ma_rdata(ma_rdata),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .cpu_hold(cpu_hold)
  );

  rip_mem_arbiter #(.STARVE_LIMIT(0)) dut_z (
    .clk(clk), .rst(rst),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_we(ld_we), .ld_wdata(ld_wdata), .ld_gnt(z_ld_gnt),
    .ma_req(ma_req), .ma_addr(ma_addr), .ma_we(ma_we), .ma_wdata(ma_wdata), .ma_gnt(z_ma_gnt),
    .ma_rvalid(z_ma_rvalid), .ma_rdata(z_ma_rdata),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(z_if_gnt), .if_rvalid(z_if_rvalid), .if_rdata(z_if_rdata),
    .mem_en(z_mem_en), .mem_addr(z_mem_addr), .mem_we(z_mem_we), .mem_wdata(z_mem_wdata),
    .mem_rdata(z_mem_rdata), .cpu_hold(z_cpu_hold)
  );

  // Bench-side RAM with one cycle read latency
  logic [DATA_WIDTH-1:0] ram     [0:DEPTH-1];
  logic [DATA_WIDTH-1:0] ref_mem [0:DEPTH-1];

  always @(posedge clk) begin
    if (mem_en) begin
      mem_rdata <= ram[mem_addr];
      for (int b = 0; b < NUM_COL; b++)
        if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  int                    m_cnt  = 0;
  bit                    m_load = 0;
  int                    m_pend = 0;
  logic [DATA_WIDTH-1:0] m_pdata = '0;
  bit                    e_ld, e_if, e_ma, e_en, e_zif, e_zma;
  int                    e_widx;
  logic [NUM_COL-1:0]    e_we;
  logic [DATA_WIDTH-1:0] e_wd;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_ld_gnt", ld_gnt, 0);
      chk("rst_ma_gnt", ma_gnt, 0);
      chk("rst_if_gnt", if_gnt, 0);
      chk("rst_ma_rvalid", ma_rvalid, 0);
      chk("rst_if_rvalid", if_rvalid, 0);
      chk("rst_mem_en", mem_en, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_cpu_hold", cpu_hold, 0);
      chk("rst_z_if_gnt", z_if_gnt, 0);
      m_load = 0;
      m_cnt  = 0;
      m_pend = 0;
    end else begin
      e_ld = ld_req;
      e_if = !m_load && !ld_req && if_req && (m_cnt >= LIMIT || !ma_req);
      e_ma = !m_load && !ld_req && ma_req && !e_if;
      e_en = e_ld || e_if || e_ma;
      e_widx = 0;
      e_we = '0;
      e_wd = '0;
      if (e_ld) begin
        e_widx = int'((ld_addr >> 2) % DEPTH); e_we = ld_we; e_wd = ld_wdata;
      end else if (e_ma) begin
        e_widx = int'((ma_addr >> 2) % DEPTH); e_we = ma_we; e_wd = ma_wdata;
      end else if (e_if) begin
        e_widx = int'((if_addr >> 2) % DEPTH);
      end
      chk("ld_gnt", ld_gnt, e_ld);
      chk("ma_gnt", ma_gnt, e_ma);
      chk("if_gnt", if_gnt, e_if);
      chk("mem_en", mem_en, e_en);
      chk("mem_addr", mem_addr, e_widx);
      chk("mem_we", mem_we, e_we);
      chk("mem_wdata", mem_wdata, e_wd);
      chk("cpu_hold", cpu_hold, m_load);
      chk("if_rvalid", if_rvalid, m_pend == 1);
      chk("ma_rvalid", ma_rvalid, m_pend == 2);
      if (m_pend == 1) chk("if_rdata", if_rdata, m_pdata);
      if (m_pend == 2) chk("ma_rdata", ma_rdata, m_pdata);

      // A zero starvation limit means fetch always beats data
      e_zif = !m_load && !ld_req && if_req;
      e_zma = !m_load && !ld_req && ma_req && !if_req;
      chk("z_if_gnt", z_if_gnt, e_zif);
      chk("z_ma_gnt", z_ma_gnt, e_zma);
      chk("z_cpu_hold", z_cpu_hold, m_load);

      if (e_if || (e_ma && ma_we == 0)) begin
        m_pend  = e_if ? 1 : 2;
        m_pdata = ref_mem[e_widx];
      end else begin
        m_pend = 0;
      end
      if (e_en)
        for (int b = 0; b < NUM_COL; b++)
          if (e_we[b]) ref_mem[e_widx][8*b +: 8] = e_wd[8*b +: 8];
      if (!m_load) m_cnt = (!if_req || e_if) ? 0 : ((m_cnt < LIMIT) ? m_cnt + 1 : m_cnt);
      if (!m_load && e_ld) m_load = 1;
      else if (m_load && !ld_req) m_load = 0;
    end
  end

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ld_req = 0; ma_req = 0; if_req = 0; ma_we = '0;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ram[i]     = 32'hA000_0000 + i;
      ref_mem[i] = 32'hA000_0000 + i;
    end
    rst = 1;
    ld_req = 1; ma_req = 1; if_req = 1;
    ld_addr = '0; ld_we = 4'b1111; ld_wdata = 32'h1111_1111;
    ma_addr = '0; ma_we = '0; ma_wdata = '0; if_addr = '0;

    // Reset with every request asserted, then release
    go(); go(); #1;
    chk("lit_rst_ld_gnt", ld_gnt, 0);
    chk("lit_rst_mem_en", mem_en, 0);
    go(); rst = 0; #1;
    chk("lit_rel_ld_gnt", ld_gnt, 1);
    go(); idle(); #1;
    chk("lit_rel_cpu_hold", cpu_hold, 1);
    chk("lit_rel_ma_gnt", ma_gnt, 0);
    go(); #1;
    chk("lit_rel_run", cpu_hold, 0);

    // MA beats IF; read at 0x10 hits word 4
    go(); ma_req = 1; ma_addr = 32'h10; if_req = 1; if_addr = 32'h40; #1;
    chk("lit_ma_gnt", ma_gnt, 1);
    chk("lit_ma_addr", mem_addr, 4);
    chk("lit_if_refused", if_gnt, 0);
    go(); idle(); #1;
    chk("lit_ma_rvalid", ma_rvalid, 1);
    chk("lit_ma_rdata", ma_rdata, 32'hA000_0004);
    chk("lit_if_rvalid_0", if_rvalid, 0);

    // Starvation: MA for 4 cycles, then IF, then MA
    for (int i = 0; i < 6; i++) begin
      go(); ma_req = 1; if_req = 1; ma_addr = 32'h100 + 4 * i; if_addr = 32'h200; #1;
      chk("lit_starve_ma", ma_gnt, i != 4);
      chk("lit_starve_if", if_gnt, i == 4);
    end
    go(); idle(); #1;

    // Loader burst of three full-word writes with the core requesting throughout
    for (int i = 0; i < 5; i++) begin
      go();
      ld_req = (i < 3); ld_we = 4'b1111; ld_addr = 32'h20 + 4 * i; ld_wdata = 32'hC0DE_0000 + i;
      ma_req = 1; ma_we = '0; ma_addr = 32'h50; if_req = 1; if_addr = 32'h54;
      #1;
      chk("lit_ld_cpu_hold", cpu_hold, (i >= 1) && (i <= 3));
      if (i <= 3) begin
        chk("lit_ld_ma_gnt", ma_gnt, 0);
        chk("lit_ld_if_gnt", if_gnt, 0);
      end
      if (i < 3) begin
        chk("lit_ld_gnt", ld_gnt, 1);
        chk("lit_ld_mem_we", mem_we, 4'b1111);
      end
    end
    go(); idle(); ma_req = 1; ma_addr = 32'h24; #1;
    go(); idle(); #1;
    chk("lit_ld_readback", ma_rdata, 32'hC0DE_0001);

    // IF and LD rise together: LD wins
    go(); if_req = 1; if_addr = 32'h8; ld_req = 1; ld_addr = 32'h60; ld_wdata = 32'h600D_F00D; #1;
    chk("lit_ldif_ld_gnt", ld_gnt, 1);
    chk("lit_ldif_if_gnt", if_gnt, 0);
    go(); idle(); #1;
    chk("lit_ldif_no_rvalid", if_rvalid, 0);
    go(); #1;

    // IF granted the cycle before LD: its data still comes back
    go(); if_req = 1; if_addr = 32'h8; #1;
    chk("lit_if_first", if_gnt, 1);
    go(); if_req = 0; ld_req = 1; ld_addr = 32'h64; #1;
    chk("lit_if_ret_rvalid", if_rvalid, 1);
    chk("lit_if_ret_rdata", if_rdata, 32'hA000_0002);
    go(); idle(); #1;
    chk("lit_if_ret_hold", cpu_hold, 1);
    go(); #1;

    // Byte-lane MA write returns nothing; read-back shows only lane 1 changed
    go(); ma_req = 1; ma_we = 4'b0010; ma_addr = 32'h30; ma_wdata = 32'h1234_5678; #1;
    chk("lit_maw_we", mem_we, 4'b0010);
    go(); ma_we = '0; #1;
    chk("lit_maw_no_rvalid", ma_rvalid, 0);
    go(); idle(); #1;
    chk("lit_maw_readback", ma_rdata, 32'hA000_560C);

    // Reset between grant and return drops the return
    go(); ma_req = 1; ma_addr = 32'h10; #1;
    chk("lit_mid_gnt", ma_gnt, 1);
    go(); rst = 1; idle(); #1;
    chk("lit_mid_rst_rvalid", ma_rvalid, 0);
    go(); rst = 0; #1;
    chk("lit_mid_after_rvalid", ma_rvalid, 0);

    // Mixed traffic table, checked by the model only
    for (int i = 0; i < 40; i++) begin
      go();
      ld_req   = (i % 13 == 5) || (i % 13 == 6);
      ld_we    = (i % 2 == 1) ? 4'b1111 : 4'b0000;
      ld_addr  = 32'h80 + 4 * (i % 16);
      ld_wdata = 32'h5A00_0000 + i;
      ma_req   = (i % 3 != 0);
      ma_we    = (i % 5 == 1) ? 4'b1100 : 4'b0000;
      ma_addr  = 32'h80 + 4 * (i % 8);
      ma_wdata = i * 32'h0101_0101;
      if_req   = (i % 2 == 0) || (i % 7 == 3);
      if_addr  = 32'h80 + 4 * (i % 10);
    end
    go(); idle();
    go(); go();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rip_mem_arbiter.md
# rip_mem_arbiter

Single-port memory arbiter that shares one word-addressed, byte-lane-writable synchronous RAM between three requesters: the program loader (LD), the memory-access stage (MA) and instruction fetch (IF). It sits between the core pipeline and a single-port memory array with 1-cycle read latency. It grants at most one access per cycle and routes read data back to the owning requester. It also runs a RUN/LOAD mode machine that holds the core while the loader owns the memory.

## Interface
- `STARVE_LIMIT`, default 4: number of consecutive cycles IF may be refused before it outranks MA.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `ld_req` / `ld_addr` / `ld_we` / `ld_wdata`  in  1 / DATA_WIDTH / NUM_COL / DATA_WIDTH  loader request; write-only port.
- `ld_gnt`  out  1  loader access accepted this cycle.
- `ma_req` / `ma_addr` / `ma_we` / `ma_wdata`  in  1 / DATA_WIDTH / NUM_COL / DATA_WIDTH  data request; `ma_we == 0` means read.
- `ma_gnt`  out  1  data access accepted this cycle.
- `ma_rvalid` / `ma_rdata`  out  1 / DATA_WIDTH  data read return.
- `if_req` / `if_addr`  in  1 / DATA_WIDTH  fetch request; always a read.
- `if_gnt`  out  1  fetch accepted this cycle.
- `if_rvalid` / `if_rdata`  out  1 / DATA_WIDTH  fetch return.
- `mem_en` / `mem_addr` / `mem_we` / `mem_wdata`  out  1 / ADDR_WIDTH / NUM_COL / DATA_WIDTH  memory port.
- `mem_rdata`  in  DATA_WIDTH  memory read data, valid the cycle after `mem_en`.
- `cpu_hold`  out  1  asserted while in LOAD mode.

## Operation
- Word address: `mem_addr = addr[ADDR_WIDTH+1:2]`. Byte lanes and data are passed through unchanged; alignment is the requester's job.
- At most one grant per cycle. When a grant is issued, `mem_en` is 1 and the `mem_*` outputs carry the winner's request. Otherwise `mem_en` and `mem_we` are 0.
- RUN priority:
  - `ld_req` wins over everything.
  - Otherwise, if `starve_cnt == STARVE_LIMIT` and `if_req` is high, IF wins.
  - Otherwise MA wins over IF.
- LOAD priority: only LD is grantable. `ma_gnt = if_gnt = 0`.
- Mode FSM:
  - RUN → LOAD when `ld_gnt` is high.
  - LOAD → RUN on the first cycle in LOAD with `ld_req == 0`.
  - `cpu_hold` = (state == LOAD), registered.
- `starve_cnt`:
  - Resets to 0 when `if_gnt` is high or `if_req` is low.
  - Otherwise increments, saturating at `STARVE_LIMIT`.
  - Holds its value in LOAD.
- Return tag `owner_q` is registered each cycle:
  - OWN_IF on an IF grant.
  - OWN_MA on an MA read grant (`ma_we == 0`).
  - OWN_NONE otherwise, including LD grants and MA writes.
- `if_rvalid = (owner_q == OWN_IF)` and `ma_rvalid = (owner_q == OWN_MA)`. Both `*_rdata` outputs equal `mem_rdata`.
- LD grants with `ld_we == 0` are performed as a no-op read; no data is returned.

## Timing
- Grants are combinational from `*_req` and registered state, with zero latency.
- Read data returns exactly 1 cycle after the grant. Back-to-back grants pipeline fully, so throughput is one access per cycle.
- A read granted in the same cycle that LD triggers LOAD entry still returns its rvalid the next cycle.
- Reset values:
  - `ld_gnt`, `ma_gnt`, `if_gnt`, `ma_rvalid`, `if_rvalid`, `mem_en`, `mem_we`, `cpu_hold` = 0.
  - State = RUN, `starve_cnt` = 0, `owner_q` = OWN_NONE.
  - `mem_addr`, `mem_wdata` = 0.
- Reset asserted mid-transaction drops any pending rvalid; no return is issued after reset is released.
- `STARVE_LIMIT = 0` means IF always outranks MA. The counter width is `$clog2(STARVE_LIMIT+1)`, minimum 1 bit.

## Structure
- Add to `rip_common`:
  - `arb_owner_t` enum: OWN_NONE, OWN_IF, OWN_MA, OWN_LD.
  - `arb_state_t` enum: ARB_RUN, ARB_LOAD.
- Reuse `DATA_WIDTH`, `ADDR_WIDTH`, `NUM_COL` from `rip_common`.
- No sub-module: priority logic, FSM, counter and tag register all live in a single module.

## Test plan
- Reset with all requests high → all outputs 0 during reset. On the first cycle after release, `ld_gnt = 1` and state becomes LOAD the next cycle.
- RUN, `ma_req` + `if_req` both high, MA read at `0x10` → `ma_gnt = 1`, `mem_addr = 4`. Next cycle `ma_rvalid = 1` with `mem_rdata`, and `if_rvalid = 0`.
- `STARVE_LIMIT = 4`, `ma_req` and `if_req` held high → MA granted cycles 0-3, IF granted cycle 4, `starve_cnt` returns to 0, MA granted again in cycle 5.
- `ld_req` pulses for 3 cycles with `ld_we = 4'b1111` → 3 writes, `cpu_hold = 1` for cycles 1-3, state back to RUN at cycle 4, and `ma_gnt` and `if_gnt` are 0 throughout.
- IF read granted in the same cycle that `ld_req` rises → LD wins and IF is refused. Repeat with IF granted the cycle before `ld_req` → `if_rvalid = 1` during the first LOAD cycle.
- MA write `ma_we = 4'b0010` → `mem_we = 4'b0010`, and no `ma_rvalid` the following cycle.
